irq_priority_sequencer: RTL and testbench

Priority resolver and interrupt-acknowledge sequencer for the 8259-compatible PIC. It sits between the IR input pins and the control block. It holds the IRR and ISR registers and resolves priority in fixed or rotating order, with fully nested masking by ISR. It runs the two-pulse INTA sequence, drives the vector byte onto the data bus, and executes EOI and rotation commands decoded from OCW2.

---
 rtl/irq_priority_sequencer.sv | 158 +++++++++++++++
 tb/tb_irq_priority_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_priority_sequencer.sv
// irq_priority_sequencer: 8259-style IRR/ISR priority resolver and two-pulse INTA sequencer.
// Priority runs upward from lowest_prio+1 with wrap-around; requests are fully nested under ISR.
module irq_priority_sequencer #(
    parameter int VECTOR_BASE_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init_clear,
    input  logic [7:0]               ir,
    input  logic                     level_triggered,
    input  logic [7:0]               int_mask,
    input  logic [VECTOR_BASE_W-1:0] vector_base,
    input  logic                     auto_eoi,
    input  logic                     int_ack_n,
    input  logic                     eoi_valid,
    input  logic [2:0]               eoi_cmd,
    input  logic [2:0]               eoi_level,
    output logic                     int_req,
    output logic [7:0]               data_out,
    output logic                     data_out_en,
    output logic [7:0]               irr,
    output logic [7:0]               isr
);
    typedef enum logic [1:0] {IDLE, ACK1, GAP, ACK2} state_t;

    state_t     r_state;
    logic [7:0] r_irr, r_isr, r_ir_prev, r_data_out;
    logic [2:0] r_lowest_prio, r_ack_level;
    logic       r_rotate_aeoi, r_spurious, r_int_req, r_data_out_en, r_ack_n_prev;

    // Returns {found, level} of the highest-priority set bit; smaller k wins.
    function automatic logic [3:0] f_highest(input logic [7:0] vec, input logic [2:0] lowest);
        logic [3:0] res;
        logic [2:0] lvl;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            lvl = lowest + 3'(k) + 3'd1;
            if (vec[lvl]) res = {1'b1, lvl};
        end
        return res;
    endfunction

    function automatic logic [2:0] f_rank(input logic [2:0] lvl, input logic [2:0] lowest);
        return lvl - lowest - 3'd1;
    endfunction

    logic       w_ack_fall, w_ack_rise, w_ack1_latch, w_ack2_exit, w_aeoi, w_req_cond;
    logic [3:0] w_cand, w_isr_top;
    logic [7:0] w_ack_set, w_eoi_clr, w_aeoi_clr, w_edge_set, w_vector;
    logic       w_prio_load;
    logic [2:0] w_eoi_prio;

    always_comb begin
        w_ack_fall   = r_ack_n_prev & ~int_ack_n;
        w_ack_rise   = ~r_ack_n_prev & int_ack_n;
        w_cand       = f_highest(r_irr & ~int_mask, r_lowest_prio);
        w_isr_top    = f_highest(r_isr, r_lowest_prio);
        w_req_cond   = w_cand[3] & (~w_isr_top[3] |
                       (f_rank(w_cand[2:0], r_lowest_prio) < f_rank(w_isr_top[2:0], r_lowest_prio)));
        w_ack1_latch = (r_state == IDLE) & w_ack_fall;
        w_ack2_exit  = (r_state == ACK2) & w_ack_rise;
        w_ack_set    = (w_ack1_latch & w_cand[3]) ? (8'd1 << w_cand[2:0]) : 8'd0;
        w_aeoi       = w_ack2_exit & auto_eoi & ~r_spurious;
        w_aeoi_clr   = w_aeoi ? (8'd1 << r_ack_level) : 8'd0;
        w_edge_set   = ir & ~r_ir_prev;
        w_vector     = 8'({vector_base, r_ack_level});

        // OCW2 decode; non-specific forms act on the current top ISR bit, if any.
        w_eoi_clr   = 8'd0;
        w_prio_load = 1'b0;
        w_eoi_prio  = eoi_level;
        if (eoi_valid) begin
            case (eoi_cmd)
                3'b001: if (w_isr_top[3]) w_eoi_clr = 8'd1 << w_isr_top[2:0];
                3'b011: w_eoi_clr = 8'd1 << eoi_level;
                3'b101: if (w_isr_top[3]) begin
                    w_eoi_clr   = 8'd1 << w_isr_top[2:0];
                    w_prio_load = 1'b1;
                    w_eoi_prio  = w_isr_top[2:0];
                end
                3'b111: begin
                    w_eoi_clr   = 8'd1 << eoi_level;
                    w_prio_load = 1'b1;
                end
                3'b110: w_prio_load = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_irr         <= 8'd0;
            r_isr         <= 8'd0;
            r_ir_prev     <= 8'd0;
            r_data_out    <= 8'd0;
            r_data_out_en <= 1'b0;
            r_int_req     <= 1'b0;
            r_lowest_prio <= 3'd7;
            r_rotate_aeoi <= 1'b0;
            r_ack_level   <= 3'd0;
            r_spurious    <= 1'b0;
            r_ack_n_prev  <= 1'b1;
        end else begin
            r_ir_prev    <= ir;
            r_ack_n_prev <= int_ack_n;
            if (init_clear) begin
                r_state       <= IDLE;
                r_irr         <= 8'd0;
                r_isr         <= 8'd0;
                r_data_out_en <= 1'b0;
                r_int_req     <= 1'b0;
                r_lowest_prio <= 3'd7;
                r_rotate_aeoi <= 1'b0;
                r_ack_level   <= 3'd0;
                r_spurious    <= 1'b0;
            end else begin
                // A new edge on the bit being acknowledged survives the ACK1 clear.
                r_irr     <= level_triggered ? ir : (((r_irr & ~w_ack_set) | w_edge_set) & ir);
                r_isr     <= (r_isr & ~w_eoi_clr & ~w_aeoi_clr) | w_ack_set;
                r_int_req <= w_ack1_latch ? 1'b0 : w_req_cond;
                if (w_prio_load)
                    r_lowest_prio <= w_eoi_prio;
                else if (w_aeoi & r_rotate_aeoi)
                    r_lowest_prio <= r_ack_level;
                if (eoi_valid && eoi_cmd == 3'b100)
                    r_rotate_aeoi <= 1'b1;
                else if (eoi_valid && eoi_cmd == 3'b000)
                    r_rotate_aeoi <= 1'b0;
                case (r_state)
                    IDLE: if (w_ack_fall) begin
                        r_state     <= ACK1;
                        r_ack_level <= w_cand[3] ? w_cand[2:0] : 3'd7;
                        r_spurious  <= ~w_cand[3];
                    end
                    ACK1: if (w_ack_rise) r_state <= GAP;
                    GAP: if (w_ack_fall) begin
                        r_state       <= ACK2;
                        r_data_out    <= w_vector;
                        r_data_out_en <= 1'b1;
                    end
                    ACK2: if (w_ack2_exit) begin
                        r_state       <= IDLE;
                        r_data_out_en <= 1'b0;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign int_req     = r_int_req;
    assign data_out    = r_data_out;
    assign data_out_en = r_data_out_en;
    assign irr         = r_irr;
    assign isr         = r_isr;
endmodule

// File: tb/tb_irq_priority_sequencer.sv
// Randomized and directed bench for irq_priority_sequencer against a pulse-counting reference model.
module tb_irq_priority_sequencer;
    localparam int VBW = 5;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           init_clear = 1'b0;
    logic [7:0]     ir = 8'd0;
    logic           level_triggered = 1'b0;
    logic [7:0]     int_mask = 8'd0;
    logic [VBW-1:0] vector_base = '0;
    logic           auto_eoi = 1'b0;
    logic           int_ack_n = 1'b1;
    logic           eoi_valid = 1'b0;
    logic [2:0]     eoi_cmd = 3'd0;
    logic [2:0]     eoi_level = 3'd0;
    logic           int_req, data_out_en;
    logic [7:0]     data_out, irr, isr;

    int n_total = 0;
    int n_bad   = 0;

    irq_priority_sequencer #(.VECTOR_BASE_W(VBW)) dut (
        .clk(clk), .reset(reset), .init_clear(init_clear), .ir(ir),
        .level_triggered(level_triggered), .int_mask(int_mask), .vector_base(vector_base),
        .auto_eoi(auto_eoi), .int_ack_n(int_ack_n), .eoi_valid(eoi_valid), .eoi_cmd(eoi_cmd),
        .eoi_level(eoi_level), .int_req(int_req), .data_out(data_out),
        .data_out_en(data_out_en), .irr(irr), .isr(isr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: INTA progress is tracked as a count of falling edges in the sequence.
    bit [7:0] m_irr, m_isr, m_dout, m_ir_prev;
    int       m_lp, m_ack, m_pulses;
    bit       m_rot, m_spur, m_req, m_den, m_ackn_prev;

    function automatic int best(input bit [7:0] v, input int lp);
        int b = -1;
        int br = 99;
        for (int lvl = 0; lvl < 8; lvl++)
            if (v[lvl] && ((lvl - lp + 15) % 8) < br) begin
                br = (lvl - lp + 15) % 8;
                b = lvl;
            end
        return b;
    endfunction

    function automatic int rank(input int lvl, input int lp);
        return (lvl - lp + 15) % 8;
    endfunction

    task automatic model_reset();
        m_irr = 0; m_isr = 0; m_dout = 0; m_ir_prev = 0;
        m_lp = 7; m_ack = 0; m_pulses = 0;
        m_rot = 0; m_spur = 0; m_req = 0; m_den = 0; m_ackn_prev = 1;
    endtask

    task automatic model_step();
        bit fall, rise;
        int cand, top, eoi_lp, aeoi_lp;
        bit [7:0] set_m, clr_m, edges;
        fall  = m_ackn_prev && !int_ack_n;
        rise  = !m_ackn_prev && int_ack_n;
        edges = ir & ~m_ir_prev;
        m_ackn_prev = int_ack_n;
        m_ir_prev   = ir;
        if (init_clear) begin
            m_irr = 0; m_isr = 0; m_lp = 7; m_ack = 0; m_pulses = 0;
            m_rot = 0; m_spur = 0; m_req = 0; m_den = 0;
            return;
        end
        cand = best(m_irr & ~int_mask, m_lp);
        top  = best(m_isr, m_lp);
        clr_m = 0; set_m = 0; eoi_lp = -1; aeoi_lp = -1;
        if (eoi_valid) begin
            case (eoi_cmd)
                3'd1: if (top >= 0) clr_m[top] = 1'b1;
                3'd3: clr_m[eoi_level] = 1'b1;
                3'd5: if (top >= 0) begin clr_m[top] = 1'b1; eoi_lp = top; end
                3'd7: begin clr_m[eoi_level] = 1'b1; eoi_lp = int'(eoi_level); end
                3'd6: eoi_lp = int'(eoi_level);
                default: ;
            endcase
        end
        m_req = (cand >= 0) && (top < 0 || rank(cand, m_lp) < rank(top, m_lp));
        if (fall && m_pulses == 0) begin
            m_pulses = 1;
            m_spur   = (cand < 0);
            m_ack    = (cand < 0) ? 7 : cand;
            if (cand >= 0) set_m[cand] = 1'b1;
            m_req = 0;
        end else if (fall && m_pulses == 1) begin
            m_pulses = 2;
            m_dout   = (8'(vector_base) << 3) | 8'(m_ack);
            m_den    = 1;
        end else if (rise && m_pulses == 2) begin
            m_pulses = 0;
            m_den    = 0;
            if (auto_eoi && !m_spur) begin
                clr_m[m_ack] = 1'b1;
                if (m_rot) aeoi_lp = m_ack;
            end
        end
        m_irr = level_triggered ? ir : (((m_irr & ~set_m) | edges) & ir);
        m_isr = (m_isr & ~clr_m) | set_m;
        if (aeoi_lp >= 0) m_lp = aeoi_lp;
        if (eoi_lp >= 0) m_lp = eoi_lp;
        if (eoi_valid && eoi_cmd == 3'd4) m_rot = 1;
        if (eoi_valid && eoi_cmd == 3'd0) m_rot = 0;
    endtask

    always @(posedge clk) if (!reset) model_step();

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        chk("int_req", int_req, m_req);
        chk("irr", irr, m_irr);
        chk("isr", isr, m_isr);
        chk("data_out_en", data_out_en, m_den);
        chk("data_out", data_out, m_dout);
    endtask

    task automatic ack_pair();
        int_ack_n = 1'b0; cyc();
        int_ack_n = 1'b1; cyc();
        int_ack_n = 1'b0; cyc();
        int_ack_n = 1'b1; cyc();
    endtask

    task automatic eoi(input logic [2:0] cmd, input logic [2:0] lvl);
        eoi_valid = 1'b1; eoi_cmd = cmd; eoi_level = lvl;
        cyc();
        eoi_valid = 1'b0;
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("arst_den", data_out_en, 0);
        chk("arst_isr", isr, 0);
        chk("arst_int_req", int_req, 0);
        @(negedge clk);
        reset = 1'b0; int_ack_n = 1'b1; ir = 8'd0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_int_req", int_req, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_den", data_out_en, 0);
        chk("rst_irr", irr, 0);
        chk("rst_isr", isr, 0);
        reset = 1'b0;
        vector_base = 5'h08;
        cyc();

        // IR3 through both INTA pulses
        ir = 8'h08; cyc();
        chk("t1_irr", irr, 8'h08);
        chk("t1_req_early", int_req, 0);
        cyc();
        chk("t1_req", int_req, 1);
        int_ack_n = 1'b0; cyc();
        chk("t1_isr", isr, 8'h08);
        chk("t1_req_ack1", int_req, 0);
        chk("t1_den_p1", data_out_en, 0);
        int_ack_n = 1'b1; cyc();
        int_ack_n = 1'b0; cyc();
        chk("t1_den_p2", data_out_en, 1);
        chk("t1_vec", data_out, 8'h43);
        int_ack_n = 1'b1; cyc();
        chk("t1_den_end", data_out_en, 0);
        ir = 8'h00; eoi(3'b011, 3'd3);
        chk("t1_eoi", isr, 8'h00);

        // IR5 in service, IR2 and IR6 pending
        ir = 8'h20; cyc(); cyc(); ack_pair();
        chk("t2_isr5", isr, 8'h20);
        ir = 8'h64; cyc(); cyc();
        chk("t2_req2", int_req, 1);
        ack_pair();
        chk("t2_vec2", data_out, 8'h42);
        cyc();
        chk("t2_ir6_blocked", int_req, 0);
        eoi(3'b001, 3'd0);
        chk("t2_nseoi", isr, 8'h20);
        cyc();
        chk("t2_ir6_still", int_req, 0);
        eoi(3'b001, 3'd0); cyc();
        chk("t2_ir6_req", int_req, 1);
        ack_pair();
        chk("t2_vec6", data_out, 8'h46);
        eoi(3'b001, 3'd0); ir = 8'h00; cyc();

        // Rotate on specific EOI, then IR5 outranks IR0
        ir = 8'h10; cyc(); cyc(); ack_pair();
        chk("t3_isr4", isr, 8'h10);
        ir = 8'h00; eoi(3'b111, 3'd4);
        chk("t3_isr0", isr, 8'h00);
        ir = 8'h21; cyc(); cyc(); ack_pair();
        chk("t3_lo5", data_out & 8'h07, 5);
        eoi(3'b001, 3'd0); cyc(); cyc(); ack_pair();
        chk("t3_lo0", data_out & 8'h07, 0);
        eoi(3'b001, 3'd0); ir = 8'h00; eoi(3'b110, 3'd7);

        // Auto-EOI with rotation
        auto_eoi = 1'b1; eoi(3'b100, 3'd0);
        ir = 8'h02; cyc(); cyc(); ack_pair();
        chk("t4_isr", isr, 8'h00);
        ir = 8'h00; cyc();
        ir = 8'h05; cyc(); cyc(); ack_pair();
        chk("t4_lo2", data_out & 8'h07, 2);
        ack_pair();
        auto_eoi = 1'b0; ir = 8'h00; eoi(3'b000, 3'd0); eoi(3'b110, 3'd7);

        // Spurious: IR4 pulse gone before INTA
        ir = 8'h10; cyc(); cyc(); ir = 8'h00; cyc(); cyc();
        ack_pair();
        chk("t5_lo7", data_out & 8'h07, 7);
        chk("t5_isr", isr, 8'h00);

        // Reset in GAP, then in ACK2
        eoi(3'b110, 3'd2);
        ir = 8'h08; cyc(); cyc();
        int_ack_n = 1'b0; cyc(); int_ack_n = 1'b1; cyc();
        async_reset();
        cyc(); ack_pair();
        chk("t6_spur", data_out & 8'h07, 7);
        chk("t6_isr", isr, 8'h00);
        ir = 8'h81; cyc(); cyc(); ack_pair();
        chk("t6_lp7", data_out & 8'h07, 0);
        eoi(3'b001, 3'd0); ir = 8'h00;
        ir = 8'h04; cyc(); cyc();
        int_ack_n = 1'b0; cyc(); int_ack_n = 1'b1; cyc(); int_ack_n = 1'b0; cyc();
        chk("t7_den", data_out_en, 1);
        async_reset();
        cyc();

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 8; b++) if ($urandom_range(0, 15) == 0) ir[b] = ~ir[b];
            if ($urandom_range(0, 63) == 0) int_mask = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 4) == 0) int_ack_n = ~int_ack_n;
            eoi_valid  = ($urandom_range(0, 9) == 0);
            eoi_cmd    = 3'($urandom);
            eoi_level  = 3'($urandom);
            init_clear = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 299) == 0) level_triggered = ~level_triggered;
            if ($urandom_range(0, 199) == 0) auto_eoi = ~auto_eoi;
            if ($urandom_range(0, 99) == 0) vector_base = VBW'($urandom);
            cyc();
        end
        eoi_valid = 1'b0; init_clear = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
